epidemic_router: RTL and testbench
==================================

EPIDEMIC_ROUTER -- requirements
Module: epidemic_router

Interface
REQ-001 Parameter NODE_ID, default 0, sets this node's source ID that is stamped on local injections.
REQ-002 Parameter ID_W, default 4, sets the source-ID field width.
REQ-003 Parameter SEQ_W, default 4, sets the sequence field width.
REQ-004 Parameter PAYLOAD_W, default 8, sets the payload width; flit width FLIT_W = ID_W+SEQ_W+PAYLOAD_W, laid out {src, seq, payload}, MSB first.
REQ-005 Parameter FIFO_DEPTH, default 4, sets the entries per input FIFO; it SHALL be a power of 2 and at least 2.
REQ-006 Parameter PORT_EN, default 4'b1111, is the mesh port enable mask, bit order {b,t,r,l}; edge nodes clear the unused bits.
REQ-007 clk  in  1  single clock; all state is updated on the rising edge.
REQ-008 rstn  in  1  reset, asynchronous and active-low.
REQ-009 i_valid_{l,r,t,b}  in  1  neighbour offers a flit.
REQ-010 i_data_{l,r,t,b}  in  FLIT_W  incoming flit.
REQ-011 o_ready_{l,r,t,b}  out  1  router can accept on that port.
REQ-012 o_valid_{l,r,t,b}  out  1  router offers a flit to the neighbour.
REQ-013 o_data_{l,r,t,b}  out  FLIT_W  outgoing flit.
REQ-014 i_ready_{l,r,t,b}  in  1  neighbour accepts.
REQ-015 i_valid_loc / i_data_loc (PAYLOAD_W) / o_ready_loc form the local inject channel.
REQ-016 o_valid_loc / o_data_loc (FLIT_W) / i_ready_loc form the local eject channel.
REQ-017 o_drop_cnt  out  16  saturating count of duplicate flits discarded.

Function
REQ-018 Handshake: a transfer SHALL occur on any cycle where valid&ready; once valid is asserted, the sender SHALL hold valid and data stable until the transfer occurs.
REQ-019 Each of the 5 inputs (l,r,t,b,loc) SHALL have a FIFO; o_ready_x = !full & PORT_EN[x], and o_ready_loc = !full.
REQ-020 Local injection SHALL be stamped on push: src=NODE_ID, seq=own counter; the counter increments per accepted injection and wraps at 2^SEQ_W.
REQ-021 The FSM SHALL have two states, IDLE and SEND.
REQ-022 In IDLE, the FSM SHALL round-robin pick one non-empty FIFO (order l,r,t,b,loc), with priority starting after the last winner.
REQ-023 Duplicate test for mesh flits: duplicate if src==NODE_ID, or if seen_valid[src] is set and seen_seq[src]==seq.
REQ-024 A duplicate flit SHALL be popped, counted in o_drop_cnt, and the FSM SHALL stay in IDLE; the next pick follows in the next cycle.
REQ-025 A new mesh flit SHALL be popped and latched, seen_seq[src]=seq and seen_valid[src]=1 written, and the FSM SHALL go to SEND with pending mask = (PORT_EN minus arrival port) plus loc.
REQ-026 A local flit SHALL be popped and latched with pending mask = PORT_EN, and SHALL NOT be echoed to loc; if PORT_EN==0 it SHALL be discarded without counting.
REQ-027 In SEND, each pending output SHALL drive o_valid with the latched flit; on its handshake that bit SHALL clear and its o_valid SHALL deassert next cycle; when the mask is empty the FSM SHALL return to IDLE.
REQ-028 Outputs SHALL be registered; latency from input handshake at cycle t to o_valid at t+2, with an empty router and no contention.
REQ-029 A stalled output SHALL block only further arbitration; the input FIFOs SHALL keep accepting until full.
REQ-030 Disabled ports SHALL keep o_valid=0 and o_ready=0, and SHALL ignore i_valid.
REQ-031 o_drop_cnt SHALL saturate at 16'hFFFF.
REQ-032 A sequence wrap SHALL be treated as new if it differs from the last stored seq for that source.

Reset
REQ-033 On rstn low, asynchronously: FIFOs empty, all o_valid=0, o_data=0, o_ready=0 while in reset, seen_valid all 0, seq counter 0, o_drop_cnt 0, FSM IDLE, RR pointer at l.
REQ-034 A reset mid-SEND SHALL abandon the latched flit with no partial delivery afterwards; after rstn rises, o_ready SHALL follow REQ-019 from the first clock.

Structure
REQ-035 Package epidemic_pkg SHALL hold the port index enum (L,R,T,B,LOC), NPORTS=5, the flit field struct, and the FSM state enum.
REQ-036 Sub-module epidemic_fifo SHALL implement a synchronous, parametrised-width/depth FIFO, instantiated 5 times.
REQ-037 The seen table SHALL be flops of depth 2^ID_W.

Verification
REQ-038 Inject payload 8'hA5 at NODE_ID=5 with PORT_EN=4'b1111 -> flit {5,0,A5} on l,r,t,b at cycle t+2, none on loc; the next injection carries seq=1.
REQ-039 Flit {3,7,11} arriving on l -> delivered on r,t,b,loc, not on l; the same flit arriving again on t -> dropped, o_drop_cnt=1, no output.
REQ-040 i_ready_r held low for 10 cycles, others high -> t,b,loc complete immediately; r completes when released; meanwhile the l FIFO fills and o_ready_l drops after FIFO_DEPTH flits.
REQ-041 Flits arriving on l,r,t,b in the same cycle with distinct srcs -> served in order l,r,t,b, each forwarded to the other 3 ports plus loc.
REQ-042 PORT_EN=4'b0011 (corner node) -> t,b stay silent and o_ready_t=o_ready_b=0; a flit arriving on l goes to r,loc only.
REQ-043 rstn asserted mid-SEND -> all o_valid drop immediately and o_drop_cnt=0; a re-sent flit {3,7,11} is accepted as new.

Source files
------------

// File: rtl/epidemic_pkg.sv
// Shared types for the epidemic flooding router.
// Port indices, flit layout, FSM states, round-robin helper.
package epidemic_pkg;

  localparam int NPORTS = 5;

  typedef enum logic [2:0] {
    P_L   = 3'd0,
    P_R   = 3'd1,
    P_T   = 3'd2,
    P_B   = 3'd3,
    P_LOC = 3'd4
  } port_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int ID_W_DEF      = 4;
  localparam int SEQ_W_DEF     = 4;
  localparam int PAYLOAD_W_DEF = 8;

  typedef struct packed {
    logic [ID_W_DEF-1:0]      src;
    logic [SEQ_W_DEF-1:0]     seq;
    logic [PAYLOAD_W_DEF-1:0] payload;
  } flit_t;

  function automatic logic [2:0] rr_next(
    input logic [2:0] p
  );
    return (p == 3'(P_LOC)) ? 3'(P_L) : p + 3'd1;
  endfunction

endpackage

// File: rtl/epidemic_fifo.sv
// Synchronous FIFO, one per router input.
// Ports: push/din/full (write), pop/dout/empty (read).
module epidemic_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr, rd;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rp];
  assign wr    = push & ~full;
  assign rd    = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      if (wr && !rd)      cnt <= cnt + (AW+1)'(1);
      else if (!wr && rd) cnt <= cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/epidemic_router.sv
// Flooding mesh router: forwards each new flit once to all
// other enabled ports plus loc, dropping duplicates seen before.
module epidemic_router
  import epidemic_pkg::*;
#(
  parameter int         NODE_ID    = 0,
  parameter int         ID_W       = 4,
  parameter int         SEQ_W      = 4,
  parameter int         PAYLOAD_W  = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] PORT_EN    = 4'b1111,
  localparam int        FLIT_W     = ID_W + SEQ_W + PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_valid_l,
  input  logic                 i_valid_r,
  input  logic                 i_valid_t,
  input  logic                 i_valid_b,
  input  logic [FLIT_W-1:0]    i_data_l,
  input  logic [FLIT_W-1:0]    i_data_r,
  input  logic [FLIT_W-1:0]    i_data_t,
  input  logic [FLIT_W-1:0]    i_data_b,
  output logic                 o_ready_l,
  output logic                 o_ready_r,
  output logic                 o_ready_t,
  output logic                 o_ready_b,
  output logic                 o_valid_l,
  output logic                 o_valid_r,
  output logic                 o_valid_t,
  output logic                 o_valid_b,
  output logic [FLIT_W-1:0]    o_data_l,
  output logic [FLIT_W-1:0]    o_data_r,
  output logic [FLIT_W-1:0]    o_data_t,
  output logic [FLIT_W-1:0]    o_data_b,
  input  logic                 i_ready_l,
  input  logic                 i_ready_r,
  input  logic                 i_ready_t,
  input  logic                 i_ready_b,
  input  logic                 i_valid_loc,
  input  logic [PAYLOAD_W-1:0] i_data_loc,
  output logic                 o_ready_loc,
  output logic                 o_valid_loc,
  output logic [FLIT_W-1:0]    o_data_loc,
  input  logic                 i_ready_loc,
  output logic [15:0]          o_drop_cnt
);

  localparam int NSRC = 2**ID_W;

  state_e state, state_n;
  logic [NPORTS-1:0] mask, mask_n;
  logic [FLIT_W-1:0] flit, flit_n;
  logic [2:0] ptr, ptr_n;
  logic [SEQ_W-1:0] seq_cnt;
  logic live;

  logic [NPORTS-1:0] push, pop, full, empty, rdy, in_v, acc;
  logic [FLIT_W-1:0] fin  [NPORTS];
  logic [FLIT_W-1:0] fout [NPORTS];

  logic [NSRC-1:0]  seen_valid;
  logic [SEQ_W-1:0] seen_seq [NSRC];

  logic found, dup, seen_we, drop_inc;
  logic [2:0] win, k;
  logic [FLIT_W-1:0] hd;
  logic [ID_W-1:0]   hd_src;
  logic [SEQ_W-1:0]  hd_seq;

  // live holds o_ready low while in reset, releases on first clock
  assign rdy[3:0] = {4{live}} & ~full[3:0] & PORT_EN;
  assign rdy[4]   = live & ~full[4];
  assign in_v     = {i_valid_loc, i_valid_b, i_valid_t,
                     i_valid_r, i_valid_l};
  assign push     = in_v & rdy;

  assign fin[0] = i_data_l;
  assign fin[1] = i_data_r;
  assign fin[2] = i_data_t;
  assign fin[3] = i_data_b;
  assign fin[4] = {ID_W'(NODE_ID), seq_cnt, i_data_loc};

  for (genvar g = 0; g < NPORTS; g++) begin : g_fifo
    epidemic_fifo #(
      .W     (FLIT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[g]),
      .din   (fin[g]),
      .full  (full[g]),
      .pop   (pop[g]),
      .dout  (fout[g]),
      .empty (empty[g])
    );
  end

  assign {o_ready_loc, o_ready_b, o_ready_t,
          o_ready_r, o_ready_l} = rdy;
  assign {o_valid_loc, o_valid_b, o_valid_t,
          o_valid_r, o_valid_l} = mask;
  assign o_data_l   = flit;
  assign o_data_r   = flit;
  assign o_data_t   = flit;
  assign o_data_b   = flit;
  assign o_data_loc = flit;

  assign acc = mask & {i_ready_loc, i_ready_b, i_ready_t,
                       i_ready_r, i_ready_l};

  // round-robin pick starting at ptr
  always_comb begin
    found = 1'b0;
    win   = 3'(P_L);
    k     = 3'(P_L);
    for (int i = 0; i < NPORTS; i++) begin
      k = 3'((int'(ptr) + i) % NPORTS);
      if (!found && !empty[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
  end

  assign hd     = fout[win];
  assign hd_src = hd[FLIT_W-1 -: ID_W];
  assign hd_seq = hd[PAYLOAD_W +: SEQ_W];
  assign dup    = (hd_src == ID_W'(NODE_ID)) ||
                  (seen_valid[hd_src] &&
                   seen_seq[hd_src] == hd_seq);

  always_comb begin
    state_n  = state;
    mask_n   = mask;
    flit_n   = flit;
    ptr_n    = ptr;
    pop      = '0;
    seen_we  = 1'b0;
    drop_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          pop[win] = 1'b1;
          ptr_n    = rr_next(win);
          if (win == 3'(P_LOC)) begin
            if (PORT_EN != 4'b0000) begin
              flit_n  = hd;
              mask_n  = {1'b0, PORT_EN};
              state_n = SEND;
            end
          end else if (dup) begin
            drop_inc = 1'b1;
          end else begin
            flit_n  = hd;
            seen_we = 1'b1;
            mask_n  = {1'b1,
                       PORT_EN & ~(4'b0001 << win)};
            state_n = SEND;
          end
        end
      end
      SEND: begin
        mask_n = mask & ~acc;
        if (mask_n == '0) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      mask       <= '0;
      flit       <= '0;
      ptr        <= 3'(P_L);
      seq_cnt    <= '0;
      live       <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      flit  <= flit_n;
      ptr   <= ptr_n;
      live  <= 1'b1;
      if (push[4]) seq_cnt <= seq_cnt + SEQ_W'(1);
      if (drop_inc && o_drop_cnt != 16'hFFFF)
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seen_valid <= '0;
      for (int i = 0; i < NSRC; i++) seen_seq[i] <= '0;
    end else if (seen_we) begin
      seen_valid[hd_src] <= 1'b1;
      seen_seq[hd_src]   <= hd_seq;
    end
  end

endmodule

// File: tb/tb_epidemic_router.sv
// Directed bench for epidemic_router: full node (id 5)
// and a corner node (PORT_EN 0011) side by side.
module tb_epidemic_router;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  iv, ir, orr, ov;
  logic [15:0] idt [4];
  logic [15:0] od  [4];
  logic        ivl, irl, orl, ovl;
  logic [7:0]  idl;
  logic [15:0] odl, drop;
  logic [4:0]  ovec;
  assign ovec = {ovl, ov};

  logic [3:0]  iv2, ir2, orr2, ov2;
  logic [15:0] idt2 [4];
  logic [15:0] od2  [4];
  logic        ivl2, irl2, orl2, ovl2;
  logic [7:0]  idl2;
  logic [15:0] odl2, drop2;
  logic [4:0]  ovec2;
  assign ovec2 = {ovl2, ov2};

  int n_vec = 0;
  int n_err = 0;

  epidemic_router #(
    .NODE_ID (5),
    .PORT_EN (4'b1111)
  ) u_dut (
    .clk (clk), .rstn (rstn),
    .i_valid_l (iv[0]), .i_valid_r (iv[1]),
    .i_valid_t (iv[2]), .i_valid_b (iv[3]),
    .i_data_l (idt[0]), .i_data_r (idt[1]),
    .i_data_t (idt[2]), .i_data_b (idt[3]),
    .o_ready_l (orr[0]), .o_ready_r (orr[1]),
    .o_ready_t (orr[2]), .o_ready_b (orr[3]),
    .o_valid_l (ov[0]), .o_valid_r (ov[1]),
    .o_valid_t (ov[2]), .o_valid_b (ov[3]),
    .o_data_l (od[0]), .o_data_r (od[1]),
    .o_data_t (od[2]), .o_data_b (od[3]),
    .i_ready_l (ir[0]), .i_ready_r (ir[1]),
    .i_ready_t (ir[2]), .i_ready_b (ir[3]),
    .i_valid_loc (ivl), .i_data_loc (idl),
    .o_ready_loc (orl), .o_valid_loc (ovl),
    .o_data_loc (odl), .i_ready_loc (irl),
    .o_drop_cnt (drop)
  );

  epidemic_router #(
    .NODE_ID (2),
    .PORT_EN (4'b0011)
  ) u_corner (
    .clk (clk), .rstn (rstn),
    .i_valid_l (iv2[0]), .i_valid_r (iv2[1]),
    .i_valid_t (iv2[2]), .i_valid_b (iv2[3]),
    .i_data_l (idt2[0]), .i_data_r (idt2[1]),
    .i_data_t (idt2[2]), .i_data_b (idt2[3]),
    .o_ready_l (orr2[0]), .o_ready_r (orr2[1]),
    .o_ready_t (orr2[2]), .o_ready_b (orr2[3]),
    .o_valid_l (ov2[0]), .o_valid_r (ov2[1]),
    .o_valid_t (ov2[2]), .o_valid_b (ov2[3]),
    .o_data_l (od2[0]), .o_data_r (od2[1]),
    .o_data_t (od2[2]), .o_data_b (od2[3]),
    .i_ready_l (ir2[0]), .i_ready_r (ir2[1]),
    .i_ready_t (ir2[2]), .i_ready_b (ir2[3]),
    .i_valid_loc (ivl2), .i_data_loc (idl2),
    .o_ready_loc (orl2), .o_valid_loc (ovl2),
    .o_data_loc (odl2), .i_ready_loc (irl2),
    .o_drop_cnt (drop2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [15:0] f);
    iv[p]  = 1'b1;
    idt[p] = f;
    tick();
    iv[p]  = 1'b0;
  endtask

  task automatic inject(input logic [7:0] pl);
    ivl = 1'b1;
    idl = pl;
    tick();
    ivl = 1'b0;
  endtask

  logic [15:0] fl [4];

  initial begin
    iv = '0; ir = 4'hF; ivl = 1'b0; irl = 1'b1; idl = '0;
    iv2 = '0; ir2 = 4'hF; ivl2 = 1'b0; irl2 = 1'b1;
    idl2 = '0;
    for (int i = 0; i < 4; i++) begin
      idt[i] = '0;
      idt2[i] = '0;
    end
    fl[0] = 16'h10A1; fl[1] = 16'h20A2;
    fl[2] = 16'h70A7; fl[3] = 16'h80A8;

    // reset state
    tick(); tick();
    chk("rst_ovec", ovec, 5'b0);
    chk("rst_ready", {orl, orr}, 5'b0);
    chk("rst_drop", drop, 16'h0);
    chk("rst_data", od[0], 16'h0);
    rstn = 1'b1;
    tick();
    chk("rdy_after_rst", {orl, orr}, 5'b11111);

    // corner node: t,b disabled and ignored
    iv2[2] = 1'b1; idt2[2] = 16'h4411;
    iv2[3] = 1'b1; idt2[3] = 16'h4522;
    tick();
    chk("c_ready", {orl2, orr2}, 5'b10011);
    iv2[0] = 1'b1; idt2[0] = 16'h3711;
    tick();
    iv2[0] = 1'b0;
    tick();
    chk("c_fwd", ovec2, 5'b10010);
    chk("c_data", od2[1], 16'h3711);
    tick();
    chk("c_done", ovec2, 5'b0);
    tick(); tick();
    chk("c_silent", ovec2, 5'b0);
    chk("c_drop", drop2, 16'h0);
    iv2 = '0;

    // local injection
    inject(8'hA5);
    tick();
    chk("inj_ovec", ovec, 5'b01111);
    chk("inj_data", od[2], 16'h50A5);
    tick();
    chk("inj_done", ovec, 5'b0);
    inject(8'h3C);
    tick();
    chk("inj2_data", od[0], 16'h513C);
    chk("inj2_ovec", ovec, 5'b01111);
    tick();

    // four simultaneous arrivals
    for (int p = 0; p < 4; p++) begin
      iv[p] = 1'b1;
      idt[p] = fl[p];
    end
    tick();
    iv = '0;
    for (int p = 0; p < 4; p++) begin
      tick();
      chk($sformatf("rr_ovec%0d", p), ovec,
          5'b10000 | (5'b01111 & ~(5'b1 << p)));
      chk($sformatf("rr_data%0d", p), odl, fl[p]);
      tick();
    end

    // new mesh flit, then duplicate on t
    send(0, 16'h3711);
    tick();
    chk("new_ovec", ovec, 5'b11110);
    chk("new_loc", odl, 16'h3711);
    tick();
    chk("new_done", ovec, 5'b0);
    send(2, 16'h3711);
    tick();
    chk("dup_ovec", ovec, 5'b0);
    chk("dup_drop", drop, 16'd1);
    send(1, 16'h5312);
    tick();
    chk("own_ovec", ovec, 5'b0);
    chk("own_drop", drop, 16'd2);

    // stalled r output, l FIFO fills
    ir[1] = 1'b0;
    send(0, 16'h4122);
    tick();
    chk("st_ovec", ovec, 5'b11110);
    tick();
    chk("st_r_only", ovec, 5'b00010);
    iv[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idt[0] = 16'h6040 + 16'(k) * 16'h0101;
      tick();
    end
    iv[0] = 1'b0;
    chk("st_full_l", orr[0], 1'b0);
    chk("st_rdy_r", orr[1], 1'b1);
    for (int k = 0; k < 4; k++) tick();
    chk("st_hold", ovec, 5'b00010);
    ir[1] = 1'b1;
    tick();
    chk("st_rel", ovec, 5'b0);
    tick();
    chk("q0_ovec", ovec, 5'b11110);
    chk("q0_data", od[1], 16'h6040);
    for (int k = 0; k < 7; k++) tick();
    chk("q_drained", ovec, 5'b0);
    chk("q_rdy_l", orr[0], 1'b1);
    chk("q_drop", drop, 16'd2);

    // reset mid-SEND
    ir = 4'h0; irl = 1'b0;
    send(0, 16'h9255);
    tick();
    chk("ms_ovec", ovec, 5'b11110);
    tick();
    rstn = 1'b0;
    #1;
    chk("ms_rst_ovec", ovec, 5'b0);
    chk("ms_rst_drop", drop, 16'h0);
    chk("ms_rst_rdy", orr[0], 1'b0);
    tick();
    rstn = 1'b1;
    ir = 4'hF; irl = 1'b1;
    tick();
    chk("ms_no_part", ovec, 5'b0);
    chk("ms_rdy", orr[0], 1'b1);
    send(0, 16'h3711);
    tick();
    chk("ms_resend", ovec, 5'b11110);
    tick();

    // changed seq is new, repeat is dropped
    send(0, 16'h3811);
    tick();
    chk("seq_new", ovec, 5'b11110);
    tick();
    send(3, 16'h3811);
    tick();
    chk("seq_dup", ovec, 5'b0);
    chk("seq_drop", drop, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
